// File: rtl/ifu_inst_sram.sv
// ============================================================================
// Module   : ifu_inst_sram
// Purpose  : Preloadable instruction memory answering AR/R fetch requests
//            with fixed plus optional LFSR-random response latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_inst_sram #(
  parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          FIXED_LAT  = 1,
  parameter int          RAND_EN    = 1,
  parameter int          RAND_BITS  = 3,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int          DEPTH   = 1 << DEPTH_LOG2;
  localparam int          MAX_LAT = FIXED_LAT + (1 << RAND_BITS) - 1;
  localparam int          CNT_W   = $clog2(MAX_LAT + 1);
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [1:0]  OKAY    = 2'b00;
  localparam logic [1:0]  SLVERR  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        lfsr_q, lfsr_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic [31:0]           rd_off, ld_off;
  logic                  rd_ok, ld_ok;
  logic [DEPTH_LOG2-1:0] rd_idx, ld_idx;
  logic [CNT_W-1:0]      rand_lat;

  // Offsets wrap, so the explicit lower-bound test rejects addresses below the base.
  assign rd_off = addr_q - ADDR_BASE;
  assign ld_off = ld_addr - ADDR_BASE;
  assign rd_ok  = (addr_q[1:0] == 2'b00) && ({1'b0, rd_off} < SPAN) && (addr_q >= ADDR_BASE);
  assign ld_ok  = (ld_addr[1:0] == 2'b00) && ({1'b0, ld_off} < SPAN) && (ld_addr >= ADDR_BASE);
  assign rd_idx = rd_off[DEPTH_LOG2+1:2];
  assign ld_idx = ld_off[DEPTH_LOG2+1:2];

  assign arready = (state_q == S_IDLE);
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    rand_lat = '0;
    if (RAND_EN != 0) begin
      rand_lat = CNT_W'(lfsr_q[RAND_BITS-1:0]);
    end

    case (state_q)
      S_IDLE: begin
        if (arvalid) begin
          addr_d  = araddr;
          cnt_d   = CNT_W'(FIXED_LAT) + rand_lat;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          // Array read sees the pre-edge contents, so a same-edge load is not forwarded.
          rdata_d  = rd_ok ? mem[rd_idx] : 32'h0;
          rresp_d  = rd_ok ? OKAY : SLVERR;
          rvalid_d = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (rready) begin
          rvalid_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  // Contents survive reset; loads are accepted in every state.
  always_ff @(posedge clk) begin
    if (ld_en && ld_ok) begin
      mem[ld_idx] <= ld_data;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifu_inst_sram.sv
// ============================================================================
// Module   : tb_ifu_inst_sram
// Purpose  : Directed bench for ifu_inst_sram over three latency configurations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ifu_inst_sram;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] araddr  [3];
  logic        arvalid [3];
  logic        arready [3];
  logic [31:0] rdata   [3];
  logic [1:0]  rresp   [3];
  logic        rvalid  [3];
  logic        rready  [3];
  logic        ld_en   = 1'b0;
  logic [31:0] ld_addr = '0;
  logic [31:0] ld_data = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ifu_inst_sram #(.FIXED_LAT(1), .RAND_EN(0)) dut0 (
    .clk(clk), .rst(rst), .araddr(araddr[0]), .arvalid(arvalid[0]), .arready(arready[0]),
    .rdata(rdata[0]), .rresp(rresp[0]), .rvalid(rvalid[0]), .rready(rready[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  ifu_inst_sram #(.FIXED_LAT(3), .RAND_EN(0)) dut1 (
    .clk(clk), .rst(rst), .araddr(araddr[1]), .arvalid(arvalid[1]), .arready(arready[1]),
    .rdata(rdata[1]), .rresp(rresp[1]), .rvalid(rvalid[1]), .rready(rready[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));
  ifu_inst_sram #(.FIXED_LAT(1), .RAND_EN(1)) dut2 (
    .clk(clk), .rst(rst), .araddr(araddr[2]), .arvalid(arvalid[2]), .arready(arready[2]),
    .rdata(rdata[2]), .rresp(rresp[2]), .rvalid(rvalid[2]), .rready(rready[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  // ---------------- reference model ----------------
  int          fl [3] = '{1, 3, 1};
  bit          re [3] = '{1'b0, 1'b0, 1'b1};
  int          cyc = 0;
  logic [7:0]  lfsr_m = 8'hA5;
  logic [31:0] refmem [4096];
  bit          m_pend [3];
  int          m_due  [3];
  logic [31:0] m_addr [3];
  bit          m_rv   [3];
  logic [31:0] m_rdata[3];
  logic [1:0]  m_rresp[3];

  function automatic bit in_rng(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (64'(a) >= 64'(BASE)) && (64'(a) < 64'(BASE) + 64'd16384);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] pat(input int k);
    if (k == 0) return 32'h0000_0413;
    return 32'h1000_0000 ^ (32'(k) * 32'h9E37_79B9);
  endfunction

  initial begin
    for (int i = 0; i < 4096; i++) refmem[i] = '0;
    for (int i = 0; i < 3; i++) begin
      araddr[i] = '0; arvalid[i] = 1'b0; rready[i] = 1'b0;
      m_pend[i] = 1'b0; m_rv[i] = 1'b0; m_due[i] = 0; m_addr[i] = '0;
      m_rdata[i] = '0; m_rresp[i] = 2'b00;
    end
  end

  // Response for a request handshaken at edge h appears at edge h + latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_pend[i] = 1'b0; m_rv[i] = 1'b0; m_rdata[i] = '0; m_rresp[i] = 2'b00;
      end
      lfsr_m = 8'hA5;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (m_rv[i]) begin
          if (rready[i]) m_rv[i] = 1'b0;
        end else if (m_pend[i]) begin
          if (cyc == m_due[i]) begin
            m_pend[i]  = 1'b0;
            m_rv[i]    = 1'b1;
            m_rdata[i] = in_rng(m_addr[i]) ? refmem[widx(m_addr[i])] : 32'h0;
            m_rresp[i] = in_rng(m_addr[i]) ? 2'b00 : 2'b10;
          end
        end else if (arvalid[i]) begin
          m_pend[i] = 1'b1;
          m_addr[i] = araddr[i];
          m_due[i]  = cyc + fl[i] + (re[i] ? int'(lfsr_m[2:0]) : 0);
        end
      end
      lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
    end
    if (ld_en && in_rng(ld_addr)) refmem[widx(ld_addr)] = ld_data;
    cyc++;
  end

  // Every-cycle compare of all three instances against the model.
  always begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 3; i++) begin
      logic exp_ar;
      exp_ar = !(m_pend[i] || m_rv[i]);
      n_vec++;
      if (arready[i] !== exp_ar || rvalid[i] !== m_rv[i] ||
          rdata[i] !== m_rdata[i] || rresp[i] !== m_rresp[i]) begin
        n_err++;
        $display("FAIL cycle_cmp dut%0d cyc %0d: got ar/rv/resp/data %b/%b/%b/%h expected %b/%b/%b/%h",
                 i, cyc, arready[i], rvalid[i], rresp[i], rdata[i],
                 exp_ar, m_rv[i], m_rresp[i], m_rdata[i]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the R handshake.
  task automatic do_read(input int d, input logic [31:0] a, input int hold,
                         output int lat, output logic [31:0] data, output logic [1:0] resp,
                         output logic ar_at_rv, output logic stable,
                         output logic ar_after, output logic rv_after);
    int n;
    stable = 1'b1;
    araddr[d] = a; arvalid[d] = 1'b1;
    n = 0;
    while (!arready[d] && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    arvalid[d] = 1'b0;
    lat = 0;
    while (!rvalid[d] && lat < 50) begin @(negedge clk); lat++; end
    if (n >= 50 || lat >= 50) begin
      n_vec++; n_err++;
      $display("FAIL read_timeout dut%0d addr %h: got no response expected one", d, a);
    end
    data = rdata[d]; resp = rresp[d]; ar_at_rv = arready[d];
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (rvalid[d] !== 1'b1 || rdata[d] !== data || rresp[d] !== resp || arready[d] !== 1'b0)
        stable = 1'b0;
    end
    rready[d] = 1'b1;
    @(negedge clk);
    rready[d] = 1'b0;
    ar_after = arready[d]; rv_after = rvalid[d];
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int          lat;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        ar_rv, stab, ar_af, rv_af, seen;
    int          k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_arready%0d", i), 32'(arready[i]), 32'd1);
      chk($sformatf("reset_rvalid%0d", i), 32'(rvalid[i]), 32'd0);
      chk($sformatf("reset_rdata%0d", i), rdata[i], 32'h0);
      chk($sformatf("reset_rresp%0d", i), 32'(rresp[i]), 32'd0);
    end
    chk("lfsr_model_seed", 32'(lfsr_m), 32'hA5);
    @(negedge clk);
    chk("lfsr_model_step1", 32'(lfsr_m), 32'h4A);
    @(negedge clk);
    chk("lfsr_model_step2", 32'(lfsr_m), 32'h95);

    for (int i = 0; i < 64; i++) load(BASE + 32'(4 * i), pat(i));
    load(32'h8000_3FFC, pat(4095));
    load(32'h8000_0041, 32'hBAD0_BAD0);
    load(32'h8000_4000, 32'hBAD1_BAD1);
    @(negedge clk);

    // 1: fixed latency 1
    do_read(0, BASE, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t1_latency", 32'(lat), 32'd1);
    chk("t1_rdata", data, 32'h0000_0413);
    chk("t1_rresp", 32'(resp), 32'd0);
    chk("t1_arready_during_rv", 32'(ar_rv), 32'd0);
    chk("t1_arready_after", 32'(ar_af), 32'd1);
    chk("t1_rvalid_after", 32'(rv_af), 32'd0);

    // 2: latency 3 with 5 stalled cycles
    do_read(1, BASE + 32'd4, 5, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t2_latency", 32'(lat), 32'd3);
    chk("t2_rdata", data, pat(1));
    chk("t2_stable", 32'(stab), 32'd1);
    chk("t2_arready_after", 32'(ar_af), 32'd1);
    chk("t2_rvalid_after", 32'(rv_af), 32'd0);

    // 3: error decode and boundaries
    do_read(0, 32'h8000_0002, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t3_misalign_resp", 32'(resp), 32'd2);
    chk("t3_misalign_data", data, 32'h0);
    do_read(0, 32'h7FFF_FFFC, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t3_below_resp", 32'(resp), 32'd2);
    chk("t3_below_data", data, 32'h0);
    do_read(0, 32'h8000_4000, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t3_above_resp", 32'(resp), 32'd2);
    chk("t3_above_data", data, 32'h0);
    do_read(0, 32'h8000_3FFC, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t3_last_resp", 32'(resp), 32'd0);
    chk("t3_last_data", data, pat(4095));
    do_read(0, 32'h8000_0040, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t3_dropped_load", data, pat(16));

    // 4: random latency, back-to-back
    for (int n = 0; n < 200; n++) begin
      k = $urandom_range(0, 63);
      do_read(2, BASE + 32'(4 * k), 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
      chk("t4_lat_in_range", 32'(lat >= 1 && lat <= 8), 32'd1);
      chk("t4_rdata", data, pat(k));
      chk("t4_rresp", 32'(resp), 32'd0);
    end

    // 5: reset while waiting
    araddr[1] = BASE + 32'd8; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_arready_after_rst", 32'(arready[1]), 32'd1);
    seen = 1'b0;
    repeat (8) begin @(negedge clk); seen = seen | rvalid[1]; end
    chk("t5_no_rvalid", 32'(seen), 32'd0);
    do_read(1, BASE + 32'd8, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t5_reread", data, pat(2));

    // 6: load on the capture edge returns the old word
    araddr[1] = BASE + 32'd12; arvalid[1] = 1'b1;
    @(negedge clk);
    arvalid[1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = BASE + 32'd12; ld_data = 32'hDEAD_BEEF;
    @(negedge clk);
    ld_en = 1'b0;
    chk("t6_rvalid", 32'(rvalid[1]), 32'd1);
    chk("t6_old_word", rdata[1], pat(3));
    rready[1] = 1'b1;
    @(negedge clk);
    rready[1] = 1'b0;
    do_read(1, BASE + 32'd12, 0, lat, data, resp, ar_rv, stab, ar_af, rv_af);
    chk("t6_new_word", data, 32'hDEAD_BEEF);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/ifu_inst_sram.md
Name: ifu_inst_sram

Overview:
- Instruction-memory slave that sits directly upstream of the fetch unit and answers its AXI-lite-style read-address/read-data requests.
- Backing store is an internal word array, preloaded through a simple load port.
- Response latency is fixed plus an optional LFSR-driven random part, so the fetch handshake is exercised under variable delay.
- Read-only from the core's side; no write channel.

Parameters:
- ADDR_BASE, 32'h8000_0000, byte address of word 0.
- DEPTH_LOG2, 12, log2 of the word count (4096 words).
- FIXED_LAT, 1, minimum response delay in cycles; must be >= 1.
- RAND_EN, 1, 1 = add the random delay component, 0 = fixed delay only.
- RAND_BITS, 3, number of LFSR bits added to the delay (0..7 extra cycles).
- LFSR_SEED, 8'hA5, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- araddr  in  32  read byte address from fetch
- arvalid  in  1  read address valid
- arready  out  1  slave can accept an address
- rdata  out  32  instruction word
- rresp  out  2  00 = OKAY, 10 = SLVERR
- rvalid  out  1  read data valid
- rready  in  1  fetch accepts the data
- ld_en  in  1  preload write enable
- ld_addr  in  32  preload byte address
- ld_data  in  32  preload word

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- On a reset edge: state = IDLE, rvalid = 0, rdata = 0, rresp = 00, delay counter = 0, lfsr = LFSR_SEED. The memory array is NOT reset.
- arready = (state == IDLE), combinational from the state register, so it is 1 in the first cycle after reset. rst dominates any handshake sampled on the same edge.
- States: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with arvalid & arready, latch araddr.
  - Set D = FIXED_LAT + (RAND_EN ? lfsr[RAND_BITS-1:0] : 0), using the lfsr value before that edge's update.
  - cnt <= D; go to WAIT.
- WAIT:
  - cnt decrements by 1 each edge.
  - On the edge where cnt == 1: capture the response into rdata/rresp and go to RESP.
  - rvalid therefore rises exactly D cycles after the AR handshake edge.
- RESP:
  - rvalid = 1; rdata/rresp are held stable until rvalid & rready is sampled.
  - On that edge: go to IDLE, rvalid <= 0. rdata/rresp keep their last value.
- Spacing: arready is low in WAIT and RESP, so arvalid there is ignored and no request is queued. Minimum spacing between AR handshakes is D+2 edges.
- rready while rvalid = 0 is ignored.
- Decode:
  - off = araddr - ADDR_BASE (32-bit, wraps); idx = off[31:2].
  - OKAY when araddr[1:0] == 0, off < 4*2^DEPTH_LOG2, and araddr >= ADDR_BASE: rdata = mem[idx], rresp = 00.
  - Otherwise: rdata = 32'h0, rresp = 10.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1. Shift left, new bit0 = l[7]^l[5]^l[4]^l[3]. Advances on every non-reset edge regardless of state.
- Load port:
  - On an edge with ld_en and an in-range, word-aligned ld_addr (same decode as above), write mem[idx] <= ld_data. Allowed in any state; out-of-range or misaligned loads are dropped.
  - Read-before-write: if a load hits the same word on the WAIT->RESP capture edge, rdata gets the old value.
- Reset mid-transaction (WAIT or RESP): the transaction is discarded and rvalid never asserts for it; memory contents are retained.

Test Plan:
1. RAND_EN=0, FIXED_LAT=1: preload 0x8000_0000 <= 0x0000_0413; read 0x8000_0000 with rready=1 -> rvalid high 1 cycle after the AR handshake, rdata 0x0000_0413, rresp 00, arready low until the cycle after the R handshake.
2. FIXED_LAT=3, rready held low 5 cycles after rvalid -> rvalid, rdata, rresp stable and arready=0 throughout; rready=1 -> rvalid=0 and arready=1 on the next cycle.
3. Error reads at 0x8000_0002, 0x7FFF_FFFC, 0x8000_4000 (DEPTH_LOG2=12) -> each returns rresp 10, rdata 0x0; a following read of 0x8000_3FFC returns the preloaded word with rresp 00.
4. RAND_EN=1, seed 8'hA5, 200 back-to-back reads of random preloaded words -> every latency lies in [FIXED_LAT, FIXED_LAT+7] and equals a bench LFSR model cycle for cycle; all data correct.
5. Assert rst for 1 cycle while in WAIT -> rvalid never rises for that request; arready=1 the cycle after reset; a re-read returns data preloaded before the reset.
6. ld_en writes 0xDEAD_BEEF to the word being read on the WAIT->RESP capture edge -> that response returns the old word; the next read of the address returns 0xDEAD_BEEF.
